coreir_mem_sync: RTL and testbench

COREIR_MEM_SYNC -- requirements
Module: coreir_mem_sync

---
 rtl/coreir_mem_sync.sv | 126 ++++++++++++
 tb/tb_coreir_mem_sync.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/coreir_mem_sync.sv
// ============================================================================
// Module   : coreir_mem_sync
// Purpose  : Synchronous single-port-pair RAM with reset-time initialisation
//            sequence and registered 1-cycle read. Optional macro
//            COREIR_MEM_BYPASS_EN selects write-first read-during-write.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module coreir_mem_sync #(
    parameter int                      width    = 1,
    parameter int                      depth    = 2,
    parameter bit                      has_init = 1'b0,
    parameter logic [width*depth-1:0]  init     = '0,
    localparam int                     AW       = $clog2(depth)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] wdata,
    input  logic [AW-1:0]    waddr,
    input  logic             wen,
    input  logic [AW-1:0]    raddr,
    input  logic             ren,
    output logic [width-1:0] rdata,
    output logic             rvalid,
    output logic             busy
);

    localparam logic [0:0]    S_INIT  = 1'b0;
    localparam logic [0:0]    S_READY = 1'b1;
    localparam logic [AW:0]   c_depth = (AW+1)'(depth);
    localparam logic [AW-1:0] c_last  = AW'(depth - 1);

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [AW-1:0]    r_cnt;
    logic [width-1:0] r_mem [depth];
    logic [width-1:0] w_init_word [depth];
    logic             w_waddr_ok;
    logic             w_raddr_ok;
    logic             w_fwd;
    logic [width-1:0] w_rd_val;

    genvar gi;
    generate
        for (gi = 0; gi < depth; gi++) begin : g_init
            assign w_init_word[gi] = has_init ? init[gi*width +: width] : '0;
        end
    endgenerate

    // Addresses are only meaningful below depth when depth is not a power of 2
    assign w_waddr_ok = ({1'b0, waddr} < c_depth);
    assign w_raddr_ok = ({1'b0, raddr} < c_depth);

`ifdef COREIR_MEM_BYPASS_EN
    assign w_fwd = wen && w_waddr_ok && (waddr == raddr);
`else
    assign w_fwd = 1'b0;
`endif

    always_comb begin
        w_rd_val = '0;
        if (w_raddr_ok) begin
            w_rd_val = w_fwd ? wdata : r_mem[raddr];
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_INIT:  if (r_cnt == c_last) w_state_nxt = S_READY;
            default: w_state_nxt = S_READY;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (r_state == S_INIT);
    end

    always_ff @(posedge clk) begin
        if (rst || r_state != S_INIT || r_cnt == c_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Storage is never cleared directly; the INIT sweep rewrites every word
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == S_INIT) begin
                r_mem[r_cnt] <= w_init_word[r_cnt];
            end else if (wen && w_waddr_ok) begin
                r_mem[waddr] <= wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else if (r_state == S_READY) begin
            rvalid <= ren;
            if (ren) begin
                rdata <= w_rd_val;
            end
        end else begin
            rvalid <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_coreir_mem_sync.sv
// ============================================================================
// Module   : tb_coreir_mem_sync
// Purpose  : Directed self-checking bench for coreir_mem_sync (depth 4 and 3).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_coreir_mem_sync;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: depth 4
    logic       rst_a, wen_a, ren_a;
    logic [4:0] wdata_a;
    logic [1:0] waddr_a, raddr_a;
    logic [4:0] rdata_a;
    logic       rvalid_a, busy_a;

    // Instance B: depth 3 (non-power-of-2)
    logic       rst_b, wen_b, ren_b;
    logic [4:0] wdata_b;
    logic [1:0] waddr_b, raddr_b;
    logic [4:0] rdata_b;
    logic       rvalid_b, busy_b;

    coreir_mem_sync #(
        .width(5), .depth(4), .has_init(1'b1), .init(20'h04d47)
    ) u_dut_a (
        .clk(clk), .rst(rst_a), .wdata(wdata_a), .waddr(waddr_a), .wen(wen_a),
        .raddr(raddr_a), .ren(ren_a), .rdata(rdata_a), .rvalid(rvalid_a), .busy(busy_a)
    );

    coreir_mem_sync #(
        .width(5), .depth(3), .has_init(1'b1), .init(15'h1ce7)
    ) u_dut_b (
        .clk(clk), .rst(rst_b), .wdata(wdata_b), .waddr(waddr_b), .wen(wen_b),
        .raddr(raddr_b), .ren(ren_b), .rdata(rdata_b), .rvalid(rvalid_b), .busy(busy_b)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [4:0] rdw_exp;
    logic [4:0] init_a [4];
    int         n_busy;
    logic       leak;

    initial begin
        init_a[0] = 5'h07; init_a[1] = 5'h0a; init_a[2] = 5'h13; init_a[3] = 5'h00;
`ifdef COREIR_MEM_BYPASS_EN
        rdw_exp = 5'h15;
`else
        rdw_exp = 5'h0a;
`endif
        rst_a = 1'b1; wen_a = 1'b0; ren_a = 1'b0; wdata_a = '0; waddr_a = '0; raddr_a = '0;
        rst_b = 1'b1; wen_b = 1'b0; ren_b = 1'b0; wdata_b = '0; waddr_b = '0; raddr_b = '0;
        #2;
        tick();
        chk("reset_busy", busy_a, 1'b1);
        chk("reset_rvalid", rvalid_a, 1'b0);
        chk("reset_rdata", rdata_a, 5'h00);

        // Writes and reads held throughout INIT must be ignored
        rst_a = 1'b0; rst_b = 1'b0;
        wen_a = 1'b1; waddr_a = 2'd0; wdata_a = 5'h1f; ren_a = 1'b1; raddr_a = 2'd0;
        n_busy = 0; leak = 1'b0;
        while (busy_a && n_busy < 20) begin
            if (rvalid_a) leak = 1'b1;
            n_busy++;
            tick();
        end
        if (rvalid_a) leak = 1'b1;
        chk("init_busy_cycles", n_busy, 4);
        chk("init_lockout_rvalid", leak, 1'b0);
        wen_a = 1'b0; ren_a = 1'b0;

        // Back-to-back init readback
        for (int i = 0; i < 4; i++) begin
            ren_a = 1'b1; raddr_a = 2'(i);
            tick();
            chk($sformatf("init_rd%0d", i), rdata_a, init_a[i]);
            chk($sformatf("init_rv%0d", i), rvalid_a, 1'b1);
        end
        ren_a = 1'b0;

        // Write then read, then hold
        wen_a = 1'b1; waddr_a = 2'd2; wdata_a = 5'h1f;
        tick();
        wen_a = 1'b0; ren_a = 1'b1; raddr_a = 2'd2;
        tick();
        chk("wr_rd_data", rdata_a, 5'h1f);
        chk("wr_rd_valid", rvalid_a, 1'b1);
        ren_a = 1'b0;
        tick();
        chk("hold_valid", rvalid_a, 1'b0);
        chk("hold_data", rdata_a, 5'h1f);

        // Read-during-write, same address
        wen_a = 1'b1; waddr_a = 2'd1; wdata_a = 5'h15; ren_a = 1'b1; raddr_a = 2'd1;
        tick();
        chk("rdw_same", rdata_a, rdw_exp);
        wen_a = 1'b0;
        tick();
        chk("rdw_after", rdata_a, 5'h15);

        // Read-during-write, different addresses
        wen_a = 1'b1; waddr_a = 2'd3; wdata_a = 5'h0c; raddr_a = 2'd0;
        tick();
        chk("rdw_diff", rdata_a, 5'h07);
        wen_a = 1'b0; raddr_a = 2'd3;
        tick();
        chk("rdw_diff_wr", rdata_a, 5'h0c);
        ren_a = 1'b0;

        // Mid-operation reset aborts read and reinitialises storage
        wen_a = 1'b1; waddr_a = 2'd3; wdata_a = 5'h1e;
        tick();
        wen_a = 1'b0; ren_a = 1'b1; raddr_a = 2'd3; rst_a = 1'b1;
        tick();
        chk("midrst_rvalid", rvalid_a, 1'b0);
        chk("midrst_rdata", rdata_a, 5'h00);
        chk("midrst_busy", busy_a, 1'b1);
        rst_a = 1'b0; ren_a = 1'b0;
        n_busy = 0;
        while (busy_a && n_busy < 20) begin
            n_busy++;
            tick();
        end
        chk("midrst_busy_cycles", n_busy, 4);
        ren_a = 1'b1; raddr_a = 2'd3;
        tick();
        chk("midrst_rd3", rdata_a, 5'h00);
        chk("midrst_rv3", rvalid_a, 1'b1);
        ren_a = 1'b0;

        // Depth-3 instance: out-of-range accesses
        n_busy = 0;
        while (busy_b && n_busy < 20) begin
            n_busy++;
            tick();
        end
        chk("oor_idle", busy_b, 1'b0);
        wen_b = 1'b1; waddr_b = 2'd3; wdata_b = 5'h1f;
        tick();
        wen_b = 1'b0; ren_b = 1'b1; raddr_b = 2'd3;
        tick();
        chk("oor_rd3", rdata_b, 5'h00);
        chk("oor_rv3", rvalid_b, 1'b1);
        raddr_b = 2'd2;
        tick();
        chk("oor_rd2", rdata_b, 5'h07);
        raddr_b = 2'd0;
        tick();
        chk("oor_rd0", rdata_b, 5'h07);
        ren_b = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
